// File: rtl/jzjpcc_mem_pkg.sv
// Shared types for the load/store alignment unit.
//   mem_size_t     : access size encoded as funct3[1:0]
//   align_state_t  : alignment FSM states
//   mem_size_bytes : number of bytes moved by an access of a given size
package jzjpcc_mem_pkg;

    typedef enum logic [1:0] {
        MemByte   = 2'b00,
        MemHalf   = 2'b01,
        MemWord   = 2'b10,
        MemDouble = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        Idle  = 2'b00,
        Beat0 = 2'b01,
        Beat1 = 2'b10,
        Resp  = 2'b11
    } align_state_t;

    function automatic int unsigned mem_size_bytes(mem_size_t size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/jzjpcc_mem_lane_shifter.sv
// Combinational byte-lane positioner for stores.
// Builds the byte mask and write data for the first or second bus beat of an access.
//   size     : access size
//   offset   : byte offset of the access inside the bus word
//   beat_sel : 0 = first beat, 1 = second (word-crossing) beat
//   data     : right-justified store data
//   mask     : byte enables for the selected beat
//   wdata    : lane-positioned write data for the selected beat
module jzjpcc_mem_lane_shifter
    import jzjpcc_mem_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    localparam int unsigned BYTES = XLEN / 8,
    localparam int unsigned OFFW  = $clog2(BYTES)
) (
    input  mem_size_t         size,
    input  logic [OFFW-1:0]   offset,
    input  logic              beat_sel,
    input  logic [XLEN-1:0]   data,
    output logic [BYTES-1:0]  mask,
    output logic [XLEN-1:0]   wdata
);

    localparam int unsigned MASKW = 2 * BYTES;

    logic [15:0]         size_mask;
    logic [MASKW-1:0]    wide_mask;
    logic [2*XLEN-1:0]   wide_data;

    // Shift into a double-width window: the low half is the first beat, the
    // high half is whatever spills into the next bus word.
    always_comb begin
        size_mask = (16'd1 << mem_size_bytes(size)) - 16'd1;
        wide_mask = MASKW'(size_mask) << offset;
        wide_data = {{XLEN{1'b0}}, data} << (8 * offset);
        if (beat_sel) begin
            mask  = wide_mask[MASKW-1:BYTES];
            wdata = wide_data[2*XLEN-1:XLEN];
        end else begin
            mask  = wide_mask[BYTES-1:0];
            wdata = wide_data[XLEN-1:0];
        end
    end

endmodule

// File: rtl/jzjpcc_mem_align_unit.sv
// Load/store alignment engine between execute and the data-memory bus.
// Positions store data on byte lanes, splits word-crossing accesses into two
// beats, and extracts/extends load data.
//   clock, reset_n            : clock and synchronous active-low reset
//   req_*                     : access request from execute (valid/ready)
//   bus_*                     : single-beat data-memory bus (valid/ready)
//   rsp_valid/data/fault      : one-cycle completion pulse
module jzjpcc_mem_align_unit
    import jzjpcc_mem_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    localparam int unsigned BYTES = XLEN / 8,
    localparam int unsigned OFFW  = $clog2(BYTES)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_write,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [BYTES-1:0]  bus_mask,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_fault
);

    align_state_t      state_q;
    logic              write_q;
    mem_size_t         size_q;
    logic              unsigned_q;
    logic [OFFW-1:0]   off_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   hold_q;
    logic              cross_q;

    // Request decode
    mem_size_t         req_size;
    logic [OFFW-1:0]   req_off;
    logic              req_cross;
    logic              req_illegal;

    always_comb begin
        req_size    = mem_size_t'(req_funct3[1:0]);
        req_off     = req_addr[OFFW-1:0];
        req_cross   = (32'(req_off) + mem_size_bytes(req_size)) > BYTES;
        req_illegal = (XLEN == 32) && (req_size == MemDouble);
    end

    assign req_ready = (state_q == Idle);

    // The shifter sees the live request in Idle (first beat is registered on
    // accept) and the latched request otherwise (second beat).
    mem_size_t         sh_size;
    logic [OFFW-1:0]   sh_off;
    logic              sh_beat;
    logic [XLEN-1:0]   sh_data;
    logic [BYTES-1:0]  sh_mask;
    logic [XLEN-1:0]   sh_wdata;

    always_comb begin
        if (state_q == Idle) begin
            sh_size = req_size;
            sh_off  = req_off;
            sh_beat = 1'b0;
            sh_data = req_wdata;
        end else begin
            sh_size = size_q;
            sh_off  = off_q;
            sh_beat = 1'b1;
            sh_data = wdata_q;
        end
    end

    jzjpcc_mem_lane_shifter #(
        .XLEN (XLEN)
    ) u_lane_shifter (
        .size     (sh_size),
        .offset   (sh_off),
        .beat_sel (sh_beat),
        .data     (sh_data),
        .mask     (sh_mask),
        .wdata    (sh_wdata)
    );

    // Load extraction on the final beat: the word arriving now is combined
    // with the held first word when the access crossed a bus word.
    logic [XLEN-1:0]   beat_lo;
    logic [XLEN-1:0]   beat_hi;
    logic [2*XLEN-1:0] combined;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   field_mask;
    logic              sign_bit;
    logic [XLEN-1:0]   load_ext;

    always_comb begin
        if (state_q == Beat1) begin
            beat_lo = hold_q;
            beat_hi = bus_rdata;
        end else begin
            beat_lo = bus_rdata;
            beat_hi = '0;
        end
        combined = {beat_hi, beat_lo} >> (8 * off_q);
        shifted  = combined[XLEN-1:0];
        unique case (size_q)
            MemByte: begin
                field_mask = XLEN'(8'hFF);
                sign_bit   = shifted[7];
            end
            MemHalf: begin
                field_mask = XLEN'(16'hFFFF);
                sign_bit   = shifted[15];
            end
            MemWord: begin
                field_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit   = shifted[31];
            end
            default: begin
                field_mask = '1;
                sign_bit   = shifted[XLEN-1];
            end
        endcase
        load_ext = shifted & field_mask;
        if (!unsigned_q && sign_bit) begin
            load_ext = load_ext | ~field_mask;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= Idle;
            write_q    <= 1'b0;
            size_q     <= MemByte;
            unsigned_q <= 1'b0;
            off_q      <= '0;
            wdata_q    <= '0;
            hold_q     <= '0;
            cross_q    <= 1'b0;
            bus_valid  <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_mask   <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_fault  <= 1'b0;
        end else begin
            unique case (state_q)
                Idle: begin
                    rsp_valid <= 1'b0;
                    rsp_fault <= 1'b0;
                    rsp_data  <= '0;
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_funct3[2];
                        off_q      <= req_off;
                        wdata_q    <= req_wdata;
                        cross_q    <= req_cross;
                        if (req_illegal || (req_cross && !ALLOW_MISALIGNED)) begin
                            state_q   <= Resp;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                        end else begin
                            state_q   <= Beat0;
                            bus_valid <= 1'b1;
                            bus_write <= req_write;
                            bus_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                            bus_mask  <= sh_mask;
                            bus_wdata <= sh_wdata;
                        end
                    end
                end
                Beat0: begin
                    if (bus_ready) begin
                        if (!write_q) begin
                            hold_q <= bus_rdata;
                        end
                        if (cross_q) begin
                            state_q   <= Beat1;
                            bus_addr  <= bus_addr + XLEN'(BYTES);
                            bus_mask  <= sh_mask;
                            bus_wdata <= sh_wdata;
                        end else begin
                            state_q   <= Resp;
                            bus_valid <= 1'b0;
                            bus_write <= 1'b0;
                            bus_addr  <= '0;
                            bus_mask  <= '0;
                            bus_wdata <= '0;
                            rsp_valid <= 1'b1;
                            rsp_data  <= write_q ? '0 : load_ext;
                        end
                    end
                end
                Beat1: begin
                    if (bus_ready) begin
                        state_q   <= Resp;
                        bus_valid <= 1'b0;
                        bus_write <= 1'b0;
                        bus_addr  <= '0;
                        bus_mask  <= '0;
                        bus_wdata <= '0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= write_q ? '0 : load_ext;
                    end
                end
                default: begin
                    state_q   <= Idle;
                    rsp_valid <= 1'b0;
                    rsp_fault <= 1'b0;
                    rsp_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/jzjpcc_mem_align_unit.md
Name: jzjpcc_mem_align_unit

Overview:
- Parametrised load/store alignment engine between the execute stage and the data-memory bus.
- Generates byte masks and lane-shifted store data, and extracts and sign/zero-extends load data.
- Splits accesses that cross a bus word into two bus beats and merges the load result.
- Runs a small valid/ready FSM, so accesses can stall on a slow bus.

Parameters:
- XLEN, 32, data/address width; legal values are 32 or 64. BYTES = XLEN/8, OFFW = log2(BYTES).
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two beats; 0 = report a fault with no bus traffic.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  access request from execute.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  [1:0] size: 00 byte, 01 half, 10 word, 11 double. [2] = unsigned load.
- req_addr  in  XLEN  byte address (the ALU result).
- req_wdata  in  XLEN  store data (rs2), right-justified.
- bus_valid  out  1  bus beat request.
- bus_ready  in  1  bus accepts the beat; for reads, bus_rdata is valid in the same cycle.
- bus_write  out  1  beat is a write.
- bus_addr  out  XLEN  bus-word-aligned address (low OFFW bits = 0).
- bus_wdata  out  XLEN  lane-positioned write data.
- bus_mask  out  BYTES  byte enables.
- bus_rdata  in  XLEN  read data.
- rsp_valid  out  1  one-cycle completion pulse (no backpressure).
- rsp_data  out  XLEN  extended load result; 0 for stores and faults.
- rsp_fault  out  1  illegal size or disallowed misalignment.

Behaviour:
- Reset (reset_n low at a clock edge): the FSM goes to IDLE.
  - bus_valid, rsp_valid, rsp_fault, bus_write, bus_mask, bus_addr, bus_wdata and rsp_data all become 0.
  - Any in-flight access is abandoned with no response; bus_valid is low from the next cycle.
- Size bytes: SZ = 1 << funct3[1:0].
  - funct3[1:0] = 11 with XLEN = 32 is illegal.
  - Offset: off = req_addr[OFFW-1:0].
  - Crossing: off + SZ > BYTES.
- Accept: req_valid && req_ready. req_ready = (state == IDLE). Request fields are registered on accept.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE, on accept:
  - Illegal size, or crossing with ALLOW_MISALIGNED = 0: go to RESP with the fault flag set. No bus beat is issued.
  - Otherwise: go to BEAT0.
- BEAT0:
  - bus_valid = 1; bus_addr = addr with low OFFW bits cleared.
  - bus_mask = ((1 << SZ) - 1) << off, truncated to BYTES.
  - bus_wdata = wdata << (8*off), truncated to XLEN.
  - On bus_ready: for a load, latch bus_rdata into the hold register. Go to BEAT1 if crossing, else RESP.
- BEAT1:
  - bus_addr = aligned addr + BYTES, wrapping modulo 2^XLEN.
  - bus_mask = (1 << (off + SZ - BYTES)) - 1.
  - bus_wdata = wdata >> (8*(BYTES - off)).
  - On bus_ready: for a load, latch the second word. Go to RESP.
- Bus stability: while bus_valid = 1 and bus_ready = 0, all bus_* outputs hold stable.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
  - Load data: {beat1, beat0} >> (8*off). Take the low 8*SZ bits; sign-extend unless funct3[2] = 1; 32-bit words under XLEN = 64 follow the same rule.
  - Store or fault: rsp_data = 0. rsp_fault = fault flag.
- Latency: aligned access with bus_ready held high is accept at T, beat at T+1, rsp_valid at T+2. A crossing access adds one cycle. A fault gives rsp_valid at T+1.
- Back-to-back: a new accept is possible in the cycle after RESP. There is no overlap.
- bus_valid is never asserted in IDLE or RESP.

Decomposition:
- Package jzjpcc_mem_pkg holds:
  - the mem_size_t enum (BYTE, HALF, WORD, DOUBLE);
  - the align_state_t enum (IDLE, BEAT0, BEAT1, RESP);
  - a function mem_size_bytes(mem_size_t).
- Sub-module jzjpcc_mem_lane_shifter: combinational. Inputs are size, offset, beat-select and data; outputs are mask and shifted write data. It is instantiated once and muxed by state.
- Load extraction and extension stays in the top module.

Test Plan:
- XLEN = 32, SB addr 0x103, wdata 0x000000AB, bus_ready = 1 → one beat: bus_addr 0x100, mask 1000, wdata 0xAB000000; rsp_valid at T+2, rsp_data 0.
- LH addr 0x102, bus_rdata 0x80010000 → rsp_data 0xFFFF8001. The same access with funct3 = 101 (LHU) → 0x00008001.
- Misaligned LW addr 0x6:
  - beat0: addr 0x4, mask 1100, rdata 0xDDCC0000;
  - beat1: addr 0x8, mask 0011, rdata 0x0000BBAA;
  - result: rsp_data 0xBBAADDCC at T+3.
- Misaligned SW addr 0x7, wdata 0x11223344, bus_ready low for 3 cycles per beat:
  - beat0: addr 0x4, mask 1000, wdata 0x44000000, held stable through the stall;
  - beat1: addr 0x8, mask 0111, wdata 0x00112233.
- Faults:
  - ALLOW_MISALIGNED = 0, LW addr 0x2 → no bus_valid; rsp_valid at T+1 with rsp_fault = 1.
  - XLEN = 32, funct3 = 011 → same fault response.
- Reset mid-operation: reset_n low during BEAT1 stall → next cycle bus_valid = 0, req_ready = 1, no rsp_valid. A following aligned LW addr 0x0 completes normally.
